// File: rtl/seg7_scan_driver_pkg.sv
// Shared display definitions for the multiplexed seven-segment driver.
package seg7_scan_driver_pkg;

  localparam int unsigned DIGITS  = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned DATA_W  = DIGITS * NIB_W;
  localparam int unsigned GLYPH_W = 7;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned GLYPHS  = 16;

  localparam logic [DIGITS-1:0] AN_OFF  = 8'hFF;
  localparam logic [SEG_W-1:0]  SEG_OFF = 8'hFF;

  // Active-low gfedcba glyphs; entry 15 first so index n holds the glyph for hex n.
  localparam logic [GLYPHS-1:0][GLYPH_W-1:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // One registered pin update: digit enables plus segment pattern.
  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [SEG_W-1:0]  seg;
  } disp_out_t;

  // Active-low one-hot enable for the selected digit.
  function automatic logic [DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] idx);
    return ~(DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [NIB_W-1:0]   nib,
  output logic [GLYPH_W-1:0] seg_c
);

  // Table lookup of the glyph for the nibble.
  always_comb begin
    seg_c = GLYPH_TABLE[nib];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit time-multiplexed seven-segment driver with shadow capture,
// leading-zero blanking, per-digit decimal points and halt blinking.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned BLINK_SHIFT = 24
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  input  logic              freeze,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              blink,
  output logic [DIGITS-1:0] AN,
  output logic [SEG_W-1:0]  SEG
);

  localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = BLINK_SHIFT + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DATA_W-1:0]  shadow;
  logic [DIV_W-1:0]   div_cnt;
  logic [IDX_W-1:0]   idx;
  logic [BLINK_W-1:0] blink_cnt;
  disp_out_t          disp_q;

  logic [DATA_W-1:0]  upper_c;
  logic [NIB_W-1:0]   nib_c;
  logic [GLYPH_W-1:0] glyph_c;
  logic               slot_end_c;
  logic               blank_c;
  logic               dark_c;
  disp_out_t          disp_next_c;

  // Glyph for the digit currently being scanned.
  hex_to_seg7 u_hex_to_seg7 (
    .nib   (nib_c),
    .seg_c (glyph_c)
  );

  // Shadow capture; freeze holds the shown value regardless of load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= '0;
    end else if (load && !freeze) begin
      shadow <= data;
    end
  end

  // Slot divider and digit index; the index steps on the last cycle of a slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end_c) begin
      div_cnt <= '0;
      idx     <= idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Free-running blink phase counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Digit selection, leading-zero test and blanking of the next pin state.
  always_comb begin
    slot_end_c      = (div_cnt == DIV_LAST);
    upper_c         = shadow >> {idx, 2'b00};
    nib_c           = upper_c[NIB_W-1:0];
    blank_c         = blank_lz && (idx != '0) && (upper_c == '0);
    dark_c          = blink && blink_cnt[BLINK_W-1];
    disp_next_c.an  = digit_enable(idx);
    disp_next_c.seg = {~dp_mask[idx], glyph_c};
    if (blank_c || dark_c) begin
      disp_next_c.an  = AN_OFF;
      disp_next_c.seg = SEG_OFF;
    end
  end

  // AN and SEG share one register so they always change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_q.an  <= AN_OFF;
      disp_q.seg <= SEG_OFF;
    end else begin
      disp_q <= disp_next_c;
    end
  end

  assign AN  = disp_q.an;
  assign SEG = disp_q.seg;

endmodule
